ram_arbiter: RTL and testbench

Two-port arbiter that shares one `sync_ram` (synchronous-write, registered-read, 1-cycle read latency) between two requesters. Each requester issues single-word read or write commands through a req/gnt handshake. The arbiter serialises them with round-robin fairness, drives the RAM command pins from registers and returns read data with a one-hot valid strobe. It sits directly in front of `sync_ram`, whose ports (`Din`, `addr`, `writeEn`, `read`, `Dout`) connect to the `ram_*` pins below.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and sizes for the two-port sync_ram arbiter.
// Contents: FSM state enum, port count, default RAM geometry and the
// command payload struct {we, addr, wdata} sized by the default geometry.
package ram_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS);
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational winner select between two requesters.
// Ports:
//   i_req0, i_req1 : request lines
//   i_last         : port granted most recently (1 = port 1)
//   o_any_c        : some request is present
//   o_win_c        : winning port (0/1), meaningful only with o_any_c
// Build option RAM_ARB_FIXED_PRIO_EN: port 0 always wins a tie and i_last
// is ignored; otherwise a tie goes to the port not granted last.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any_c,
  output logic o_win_c
);

  assign o_any_c = i_req0 | i_req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
  // port 1 wins only when port 0 is silent
  assign o_win_c = ~i_req0;
`else
  // a lone requester wins outright; a tie goes to the port not granted last
  assign o_win_c = (i_req0 & i_req1) ? ~i_last : i_req1;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises single-word read/write commands from two
// requesters onto one sync_ram (registered read, 1-cycle latency).
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req0/1, we0/1, addr0/1, wdata0/1 : requester commands (held until gnt)
//   gnt0/1                    : one-cycle accept pulse
//   rvalid0/1, rdata          : read return strobe and shared data bus
//   ram_din/addr/writeEn/read : registered RAM command pins
//   ram_dout                  : RAM read data
// Build option RAM_ARB_FIXED_PRIO_EN: fixed priority to port 0, no
// round-robin pointer.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_writeEn,
  output logic                  ram_read,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_t                r_state, w_state_nxt;
  logic                  r_gnt0, r_gnt1, w_gnt0_nxt, w_gnt1_nxt;
  logic                  r_rvalid0, r_rvalid1, w_rvalid0_nxt, w_rvalid1_nxt;
  logic                  r_ram_we, r_ram_rd, w_ram_we_nxt, w_ram_rd_nxt;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_WIDTH-1:0] r_ram_din, w_ram_din_nxt;
  logic [PORT_W-1:0]     r_port, w_port_nxt;
  logic                  w_any, w_win, w_last;
  cmd_t                  w_cmd0, w_cmd1, w_sel;

  // Round-robin pointer: port granted most recently, port 0 wins first tie
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign w_last = 1'b1;
`else
  logic r_last, w_last_nxt;
  assign w_last = r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last <= 1'b1;
    else     r_last <= w_last_nxt;
  end
`endif

  rr_pick2 u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (w_last),
    .o_any_c (w_any),
    .o_win_c (w_win)
  );

  assign w_cmd0 = '{we: we0, addr: ADDR_W'(addr0), wdata: DATA_W'(wdata0)};
  assign w_cmd1 = '{we: we1, addr: ADDR_W'(addr1), wdata: DATA_W'(wdata1)};
  assign w_sel  = w_win ? w_cmd1 : w_cmd0;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_port     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_rvalid0  <= w_rvalid0_nxt;
      r_rvalid1  <= w_rvalid1_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_rd   <= w_ram_rd_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_port     <= w_port_nxt;
    end
  end

  // Next state and next output values; strobes default low, RAM pins hold
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt0_nxt     = 1'b0;
    w_gnt1_nxt     = 1'b0;
    w_rvalid0_nxt  = 1'b0;
    w_rvalid1_nxt  = 1'b0;
    w_ram_we_nxt   = 1'b0;
    w_ram_rd_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    w_port_nxt     = r_port;
`ifndef RAM_ARB_FIXED_PRIO_EN
    w_last_nxt     = r_last;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt    = ISSUE;
          w_port_nxt     = PORT_W'(w_win);
          w_gnt0_nxt     = ~w_win;
          w_gnt1_nxt     = w_win;
          w_ram_we_nxt   = w_sel.we;
          w_ram_rd_nxt   = ~w_sel.we;
          w_ram_addr_nxt = ADDR_WIDTH'(w_sel.addr);
          w_ram_din_nxt  = DATA_WIDTH'(w_sel.wdata);
`ifndef RAM_ARB_FIXED_PRIO_EN
          w_last_nxt     = w_win;
`endif
        end
      end
      ISSUE: begin
        // a read returns data one cycle after the RAM samples it
        if (r_ram_rd) begin
          w_state_nxt   = WAIT_RD;
          w_rvalid0_nxt = (r_port == PORT_W'(0));
          w_rvalid1_nxt = (r_port == PORT_W'(1));
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      WAIT_RD: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign ram_writeEn = r_ram_we;
  assign ram_read    = r_ram_rd;
  assign ram_addr    = r_ram_addr;
  assign ram_din     = r_ram_din;
  assign rdata       = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed stimulus for ram_arbiter, with a
// behavioural sync_ram and a transaction-level reference model
// (shadow memory, grant pointer, busy-until cycle).
module tb_ram_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_writeEn, ram_read;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_din(ram_din), .ram_addr(ram_addr),
    .ram_writeEn(ram_writeEn), .ram_read(ram_read), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // sync_ram: synchronous write, registered read
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_writeEn) mem[ram_addr] <= ram_din;
    if (ram_read)    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } tcmd_t;

  tcmd_t         q0[$], q1[$];
  bit            hold0, hold1, rnd_mode;
  int            cyc, next_edge;
  bit            m_last;
  logic [DW-1:0] shadow [16];
  bit            sh_ok [16];
  int            iss_cyc, iss_port, rv_cyc, rv_port;
  tcmd_t         iss_cmd;
  logic [DW-1:0] rv_data;
  bit            rv_ok;
  int            gnt_log[$], gnt_cyc[$];
  logic [DW-1:0] rd0_log[$], rd1_log[$];
  int            n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic tcmd_t rand_cmd();
    tcmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = AW'($urandom_range(0, 15));
    c.wdata = DW'($urandom);
    return c;
  endfunction

  function automatic tcmd_t mk(input logic we, input int a, input logic [DW-1:0] d);
    tcmd_t c;
    c.we = we; c.addr = AW'(a); c.wdata = d;
    return c;
  endfunction

  // Model: decide what the arbiter does at the edge ending this cycle
  task automatic model_pick();
    int    w;
    tcmd_t c;
    if (rst || (cyc + 1 < next_edge) || !(req0 || req1)) return;
    if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = m_last ? 0 : 1;
`endif
    end else begin
      w = req0 ? 0 : 1;
    end
    if (w == 0) begin c.we = we0; c.addr = addr0; c.wdata = wdata0; end
    else        begin c.we = we1; c.addr = addr1; c.wdata = wdata1; end
    m_last   = (w == 1);
    iss_cyc  = cyc + 1;
    iss_port = w;
    iss_cmd  = c;
    if (c.we) begin
      shadow[c.addr] = c.wdata;
      sh_ok[c.addr]  = 1'b1;
      next_edge      = cyc + 3;
    end else begin
      rv_cyc    = cyc + 2;
      rv_port   = w;
      rv_data   = shadow[c.addr];
      rv_ok     = sh_ok[c.addr];
      next_edge = cyc + 4;
    end
    if (w == 0) begin void'(q0.pop_front()); hold0 = 1'b1; end
    else        begin void'(q1.pop_front()); hold1 = 1'b1; end
  endtask

  // Requesters: hold the granted command one more cycle, then present next
  task automatic drive();
    tcmd_t c;
    if (rnd_mode) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_cmd());
      if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_cmd());
    end
    if (hold0) hold0 = 1'b0;
    else if (q0.size() > 0) begin
      c = q0[0]; req0 = 1'b1; we0 = c.we; addr0 = c.addr; wdata0 = c.wdata;
    end else req0 = 1'b0;
    if (hold1) hold1 = 1'b0;
    else if (q1.size() > 0) begin
      c = q1[0]; req1 = 1'b1; we1 = c.we; addr1 = c.addr; wdata1 = c.wdata;
    end else req1 = 1'b0;
  endtask

  task automatic sample();
    bit iss, rv;
    iss = (iss_cyc == cyc);
    rv  = (rv_cyc == cyc);
    check("gnt0",    64'(gnt0),        64'(iss && iss_port == 0));
    check("gnt1",    64'(gnt1),        64'(iss && iss_port == 1));
    check("wen",     64'(ram_writeEn), 64'(iss && iss_cmd.we));
    check("ren",     64'(ram_read),    64'(iss && !iss_cmd.we));
    check("rvalid0", 64'(rvalid0),     64'(rv && rv_port == 0));
    check("rvalid1", 64'(rvalid1),     64'(rv && rv_port == 1));
    if (iss) begin
      check("ram_addr", 64'(ram_addr), 64'(iss_cmd.addr));
      check("ram_din",  64'(ram_din),  64'(iss_cmd.wdata));
    end
    if (rv && rv_ok) check("rdata", 64'(rdata), 64'(rv_data));
    if (gnt0)    begin gnt_log.push_back(0); gnt_cyc.push_back(cyc); end
    if (gnt1)    begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
    if (rvalid0) rd0_log.push_back(rdata);
    if (rvalid1) rd1_log.push_back(rdata);
  endtask

  task automatic step();
    model_pick();
    @(posedge clk);
    cyc++;
    #1;
    sample();
    drive();
  endtask

  task automatic chk_cleared(input string tag);
    check({tag, "_gnt0"},  64'(gnt0),        64'(0));
    check({tag, "_gnt1"},  64'(gnt1),        64'(0));
    check({tag, "_rv0"},   64'(rvalid0),     64'(0));
    check({tag, "_rv1"},   64'(rvalid1),     64'(0));
    check({tag, "_wen"},   64'(ram_writeEn), 64'(0));
    check({tag, "_ren"},   64'(ram_read),    64'(0));
    check({tag, "_addr"},  64'(ram_addr),    64'(0));
    check({tag, "_din"},   64'(ram_din),     64'(0));
  endtask

  // Assert reset mid-cycle, check outputs cleared at once, release after an edge
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_cleared(tag);
    q0.delete(); q1.delete();
    hold0 = 1'b0; hold1 = 1'b0;
    m_last = 1'b1; iss_cyc = -10; rv_cyc = -10; next_edge = 0;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || hold0 || hold1 || cyc + 1 < next_edge)
           && n < 3000) begin
      step();
      n++;
    end
    check("drain_bound", 64'(n < 3000), 64'(1));
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete(); rd0_log.delete(); rd1_log.delete();
  endtask

  initial begin
    int n, cnt0, cnt1, bad;
    for (int i = 0; i < 16; i++) sh_ok[i] = 1'b0;
    cyc = 0; next_edge = 0; m_last = 1'b1; iss_cyc = -10; rv_cyc = -10;
    hold0 = 1'b0; hold1 = 1'b0; rnd_mode = 1'b0;

    #1;
    chk_cleared("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();

    // Fill: port 0 writes 2i+1 to addr i
    clear_logs();
    for (int i = 0; i < 16; i++) q0.push_back(mk(1'b1, i, DW'(2 * i + 1)));
    drain();
    check("fill_n", 64'(gnt_log.size()), 64'(16));
    if (gnt_cyc.size() == 16)
      for (int i = 1; i < 16; i++)
        check("fill_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'(2));

    // Readback: port 1 reads addr i
    clear_logs();
    for (int i = 0; i < 16; i++) q1.push_back(mk(1'b0, i, '0));
    drain();
    check("rb_n", 64'(rd1_log.size()), 64'(16));
    check("rb_rv0", 64'(rd0_log.size()), 64'(0));
    if (rd1_log.size() == 16)
      for (int i = 0; i < 16; i++) check("rb_data", 64'(rd1_log[i]), 64'(2 * i + 1));
    if (gnt_cyc.size() == 16)
      for (int i = 1; i < 16; i++)
        check("rb_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'(3));

    // Reset mid-read: assert rst while rvalid is up
    q0.push_back(mk(1'b0, 3, '0));
    n = 0;
    while (rv_cyc != cyc && n < 20) begin step(); n++; end
    check("midrd_reach", 64'(rv_cyc == cyc), 64'(1));
    check("midrd_rv0", 64'(rvalid0), 64'(1));
    #1;
    do_reset("midrd");

    // Tie after reset: port 0 first, both read 7
    clear_logs();
    q0.push_back(mk(1'b0, 3, '0));
    q1.push_back(mk(1'b0, 3, '0));
    drain();
    check("tie_n", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() == 2) begin
      check("tie_first",  64'(gnt_log[0]), 64'(0));
      check("tie_second", 64'(gnt_log[1]), 64'(1));
    end
    if (rd0_log.size() == 1) check("tie_rd0", 64'(rd0_log[0]), 64'(7));
    else                     check("tie_rd0_n", 64'(rd0_log.size()), 64'(1));
    if (rd1_log.size() == 1) check("tie_rd1", 64'(rd1_log[0]), 64'(7));
    else                     check("tie_rd1_n", 64'(rd1_log.size()), 64'(1));

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Port 0 re-requesting continuously starves port 1
    clear_logs();
    for (int i = 0; i < 6; i++) q0.push_back(mk(1'b0, 3, '0));
    q1.push_back(mk(1'b0, 3, '0));
    drain();
    check("fp_n", 64'(gnt_log.size()), 64'(7));
    if (gnt_log.size() == 7) begin
      bad = 0;
      for (int i = 0; i < 6; i++) if (gnt_log[i] != 0) bad++;
      check("fp_starve", 64'(bad), 64'(0));
    end
`else
    // Round-robin: continuous requests from both alternate
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(1'b1, i, DW'($urandom)));
      q1.push_back(mk(1'b1, 8 + i, DW'($urandom)));
    end
    drain();
    cnt0 = 0; cnt1 = 0; bad = 0;
    foreach (gnt_log[i]) begin
      if (gnt_log[i] == 0) cnt0++; else cnt1++;
      if (i > 0 && gnt_log[i] == gnt_log[i-1]) bad++;
    end
    check("rr_cnt0", 64'(cnt0), 64'(6));
    check("rr_cnt1", 64'(cnt1), 64'(6));
    check("rr_alt",  64'(bad),  64'(0));
`endif

    // Write-then-read of the same address
    do_reset("wtr");
    clear_logs();
    q0.push_back(mk(1'b1, 5, 32'hDEADBEEF));
    q1.push_back(mk(1'b0, 5, '0));
    drain();
    if (rd1_log.size() == 1) check("wtr_data", 64'(rd1_log[0]), 64'(32'hDEADBEEF));
    else                     check("wtr_n", 64'(rd1_log.size()), 64'(1));

    // Random traffic from both ports
    rnd_mode = 1'b1;
    repeat (400) step();
    rnd_mode = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
